// File: rtl/axi4_lite_reg_slave_pkg.sv
// Shared constants and types for the AXI4-Lite register slave: register map,
// response codes, CTRL bit positions and the write-channel state encoding.
package axi4_lite_reg_slave_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;

    localparam logic [7:0] OFS_ID      = 8'h00;
    localparam logic [7:0] OFS_CTRL    = 8'h04;
    localparam logic [7:0] OFS_SCRATCH = 8'h08;
    localparam logic [7:0] OFS_COUNTER = 8'h0C;

    // Word index seen on addr[3:2] for each register.
    localparam logic [1:0] IDX_ID      = OFS_ID[3:2];
    localparam logic [1:0] IDX_CTRL    = OFS_CTRL[3:2];
    localparam logic [1:0] IDX_SCRATCH = OFS_SCRATCH[3:2];
    localparam logic [1:0] IDX_COUNTER = OFS_COUNTER[3:2];

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] DEFAULT_ID_VALUE = 32'h4D59_5245;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_CLR_BIT = 1;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } wr_state_e;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_lite_reg_slave_cnt.sv
// Free-running event counter with enable, synchronous clear and natural wrap.
// Clear wins over enable so a clear beat lands exactly on zero.
module free_run_cnt #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear, increment or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave with four 32-bit registers (ID, CTRL, SCRATCH, COUNTER).
// Write and read channels run independently; all responses are registered.
module axi4_lite_reg_slave
    import axi4_lite_reg_slave_pkg::*;
#(
    parameter int unsigned ADDR_BIT_WIDTH = ADDR_W_DEFAULT,
    parameter int unsigned DATA_BIT_WIDTH = DATA_W_DEFAULT,
    parameter logic [31:0] ID_VALUE       = DEFAULT_ID_VALUE
) (
    input  logic                        i_clk,
    input  logic                        i_sync_rst,
    input  logic [ADDR_BIT_WIDTH-1:0]   i_awaddr,
    input  logic                        i_awvalid,
    output logic                        o_awready,
    input  logic [DATA_BIT_WIDTH-1:0]   i_wdata,
    input  logic [DATA_BIT_WIDTH/8-1:0] i_wstrb,
    input  logic                        i_wvalid,
    output logic                        o_wready,
    output logic [1:0]                  o_bresp,
    output logic                        o_bvalid,
    input  logic                        i_bready,
    input  logic [ADDR_BIT_WIDTH-1:0]   i_araddr,
    input  logic                        i_arvalid,
    output logic                        o_arready,
    output logic [DATA_BIT_WIDTH-1:0]   o_rdata,
    output logic [1:0]                  o_rresp,
    output logic                        o_rvalid,
    input  logic                        i_rready,
    output logic                        o_ctrl_en
);

    wr_state_e                   wr_state_q;
    logic                        aw_held_q;
    logic                        w_held_q;
    logic [ADDR_BIT_WIDTH-1:2]   awaddr_q;
    logic [DATA_BIT_WIDTH-1:0]   wdata_q;
    logic [DATA_BIT_WIDTH/8-1:0] wstrb_q;
    logic                        bvalid_q;
    logic [1:0]                  bresp_q;

    logic                        ctrl_en_q;
    logic                        ctrl_en_d;
    logic [DATA_BIT_WIDTH-1:0]   scratch_q;
    logic [DATA_BIT_WIDTH-1:0]   scratch_d;
    logic                        cnt_clr_s;
    logic [DATA_BIT_WIDTH-1:0]   cnt_s;

    logic                        rvalid_q;
    logic [DATA_BIT_WIDTH-1:0]   rdata_q;
    logic [1:0]                  rresp_q;

    logic                        awready_s;
    logic                        wready_s;
    logic                        arready_s;
    logic                        aw_fire_s;
    logic                        w_fire_s;
    logic                        ar_fire_s;
    logic                        wr_mapped_s;
    logic                        rd_mapped_s;
    logic [DATA_BIT_WIDTH-1:0]   rd_mux_s;
    logic                        unused_addr_s;

    // Readies come from registered state and are forced low during reset.
    assign awready_s = (wr_state_q == W_IDLE) & ~aw_held_q & ~i_sync_rst;
    assign wready_s  = (wr_state_q == W_IDLE) & ~w_held_q  & ~i_sync_rst;
    assign arready_s = ~rvalid_q & ~i_sync_rst;

    assign aw_fire_s = i_awvalid & awready_s;
    assign w_fire_s  = i_wvalid  & wready_s;
    assign ar_fire_s = i_arvalid & arready_s;

    assign wr_mapped_s = (awaddr_q[ADDR_BIT_WIDTH-1:4] == '0);
    assign rd_mapped_s = (i_araddr[ADDR_BIT_WIDTH-1:4] == '0);
    assign unused_addr_s = ^{i_awaddr[1:0], i_araddr[1:0]};

    // Register-bank next state; only the commit cycle of a mapped write changes it.
    always_comb begin
        ctrl_en_d = ctrl_en_q;
        scratch_d = scratch_q;
        cnt_clr_s = 1'b0;
        if ((wr_state_q == W_COMMIT) && wr_mapped_s) begin
            case (awaddr_q[3:2])
                IDX_CTRL: begin
                    if (wstrb_q[0]) begin
                        ctrl_en_d = wdata_q[CTRL_EN_BIT];
                        cnt_clr_s = wdata_q[CTRL_CLR_BIT];
                    end else begin
                        ctrl_en_d = ctrl_en_q;
                    end
                end
                IDX_SCRATCH: scratch_d = strb_merge(scratch_q, wdata_q, wstrb_q);
                default:     scratch_d = scratch_q;
            endcase
        end else begin
            scratch_d = scratch_q;
        end
    end

    // Write channel FSM: collect AW and W in any order, commit, then hold B.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            wr_state_q <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (aw_fire_s) begin
                        awaddr_q  <= i_awaddr[ADDR_BIT_WIDTH-1:2];
                        aw_held_q <= 1'b1;
                    end
                    if (w_fire_s) begin
                        wdata_q  <= i_wdata;
                        wstrb_q  <= i_wstrb;
                        w_held_q <= 1'b1;
                    end
                    if ((aw_held_q | aw_fire_s) & (w_held_q | w_fire_s)) begin
                        wr_state_q <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    bvalid_q   <= 1'b1;
                    bresp_q    <= wr_mapped_s ? RESP_OKAY : RESP_SLVERR;
                    aw_held_q  <= 1'b0;
                    w_held_q   <= 1'b0;
                    wr_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (i_bready) begin
                        bvalid_q   <= 1'b0;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: begin
                    bvalid_q   <= 1'b0;
                    wr_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // CTRL and SCRATCH storage.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            ctrl_en_q <= 1'b0;
            scratch_q <= '0;
        end else begin
            ctrl_en_q <= ctrl_en_d;
            scratch_q <= scratch_d;
        end
    end

    free_run_cnt #(
        .WIDTH (DATA_BIT_WIDTH)
    ) u_cnt (
        .clk_i (i_clk),
        .rst_i (i_sync_rst),
        .en_i  (ctrl_en_q),
        .clr_i (cnt_clr_s),
        .cnt_o (cnt_s)
    );

    // Read mux samples current register values, so a same-edge write is not visible.
    always_comb begin
        rd_mux_s = '0;
        if (rd_mapped_s) begin
            case (i_araddr[3:2])
                IDX_ID:      rd_mux_s = ID_VALUE;
                IDX_CTRL:    rd_mux_s[CTRL_EN_BIT] = ctrl_en_q;
                IDX_SCRATCH: rd_mux_s = scratch_q;
                IDX_COUNTER: rd_mux_s = cnt_s;
                default:     rd_mux_s = '0;
            endcase
        end else begin
            rd_mux_s = '0;
        end
    end

    // Read response register, held until the master accepts it.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_fire_s) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux_s;
            rresp_q  <= rd_mapped_s ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && i_rready) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rvalid_q;
        end
    end

    assign o_awready = awready_s;
    assign o_wready  = wready_s;
    assign o_arready = arready_s;
    assign o_bvalid  = bvalid_q;
    assign o_bresp   = bresp_q;
    assign o_rvalid  = rvalid_q;
    assign o_rdata   = rdata_q;
    assign o_rresp   = rresp_q;
    assign o_ctrl_en = ctrl_en_q;

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed self-checking bench for axi4_lite_reg_slave: register map, byte
// strobes, AW/W ordering, B backpressure, counter timing, SLVERR and reset.
module tb_axi4_lite_reg_slave;

    logic        i_clk = 1'b0;
    logic        i_sync_rst = 1'b1;
    logic [31:0] i_awaddr = 32'h0;
    logic        i_awvalid = 1'b0;
    logic        o_awready;
    logic [31:0] i_wdata = 32'h0;
    logic [3:0]  i_wstrb = 4'h0;
    logic        i_wvalid = 1'b0;
    logic        o_wready;
    logic [1:0]  o_bresp;
    logic        o_bvalid;
    logic        i_bready = 1'b0;
    logic [31:0] i_araddr = 32'h0;
    logic        i_arvalid = 1'b0;
    logic        o_arready;
    logic [31:0] o_rdata;
    logic [1:0]  o_rresp;
    logic        o_rvalid;
    logic        i_rready = 1'b0;
    logic        o_ctrl_en;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int b_count  = 0;

    always #4 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (!i_sync_rst && o_bvalid && i_bready) b_count <= b_count + 1;
    end

    axi4_lite_reg_slave dut (
        .i_clk(i_clk), .i_sync_rst(i_sync_rst),
        .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rvalid(o_rvalid), .i_rready(i_rready),
        .o_ctrl_en(o_ctrl_en)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_start, input int w_start,
                             input int bready_delay, output logic [1:0] resp,
                             output int commit_edge);
        int  c = 0;
        int  last_hs = 0;
        int  g = 0;
        bit  aw_done = 1'b0;
        bit  w_done = 1'b0;
        bit  aw_fire;
        bit  w_fire;
        logic [1:0] first_resp;
        while (!(aw_done && w_done) && c < 40) begin
            @(negedge i_clk);
            if (c == aw_start) begin i_awaddr = addr; i_awvalid = 1'b1; end
            if (c == w_start)  begin i_wdata = data; i_wstrb = strb; i_wvalid = 1'b1; end
            aw_fire = i_awvalid && o_awready;
            w_fire  = i_wvalid && o_wready;
            if (aw_fire) begin aw_done = 1'b1; last_hs = cyc + 1; end
            if (w_fire)  begin w_done = 1'b1;  last_hs = cyc + 1; end
            @(posedge i_clk);
            #1;
            if (aw_fire) i_awvalid = 1'b0;
            if (w_fire)  i_wvalid = 1'b0;
            c++;
        end
        if (!(aw_done && w_done)) check_eq("aw_w_handshake_timeout", 32'd0, 32'd1);
        @(negedge i_clk);
        while (!o_bvalid && g < 20) begin @(negedge i_clk); g++; end
        commit_edge = cyc;
        check_eq("bvalid_latency", commit_edge, last_hs + 1);
        first_resp = o_bresp;
        for (int k = 0; k < bready_delay; k++) begin
            check_eq("bvalid_held", {31'd0, o_bvalid}, 32'd1);
            check_eq("bresp_stable", {30'd0, o_bresp}, {30'd0, first_resp});
            check_eq("awready_low_in_resp", {31'd0, o_awready}, 32'd0);
            @(negedge i_clk);
        end
        resp = o_bresp;
        i_bready = 1'b1;
        @(posedge i_clk);
        #1 i_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int ar_edge);
        int g = 0;
        @(negedge i_clk);
        i_araddr = addr;
        i_arvalid = 1'b1;
        while (!o_arready && g < 20) begin @(negedge i_clk); g++; end
        if (!o_arready) check_eq("arready_timeout", 32'd0, 32'd1);
        ar_edge = cyc + 1;
        @(posedge i_clk);
        #1 i_arvalid = 1'b0;
        @(negedge i_clk);
        check_eq("rvalid_after_ar", {31'd0, o_rvalid}, 32'd1);
        data = o_rdata;
        resp = o_rresp;
        i_rready = 1'b1;
        @(posedge i_clk);
        #1 i_rready = 1'b0;
    endtask

    task automatic write_okay(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [1:0] r;
        int e;
        axi_write(addr, data, strb, 0, 0, 0, r, e);
        check_eq("bresp_okay", {30'd0, r}, 32'd0);
    endtask

    task automatic read_expect(input string tag, input logic [31:0] addr,
                               input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        int e;
        axi_read(addr, d, r, e);
        check_eq(tag, d, exp_data);
        check_eq({tag, "_resp"}, {30'd0, r}, {30'd0, exp_resp});
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int e0, ec, ka, bc;
        int aw_s[3];
        int w_s[3];
        logic [31:0] vals[3];
        aw_s = '{3, 0, 0};
        w_s  = '{0, 2, 0};
        vals = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

        repeat (3) @(negedge i_clk);
        check_eq("rst_awready", {31'd0, o_awready}, 32'd0);
        check_eq("rst_wready",  {31'd0, o_wready},  32'd0);
        check_eq("rst_arready", {31'd0, o_arready}, 32'd0);
        check_eq("rst_bvalid",  {31'd0, o_bvalid},  32'd0);
        check_eq("rst_rvalid",  {31'd0, o_rvalid},  32'd0);
        check_eq("rst_rdata",   o_rdata, 32'd0);
        check_eq("rst_ctrl_en", {31'd0, o_ctrl_en}, 32'd0);
        i_sync_rst = 1'b0;
        #1;
        check_eq("post_rst_awready", {31'd0, o_awready}, 32'd1);
        check_eq("post_rst_wready",  {31'd0, o_wready},  32'd1);
        check_eq("post_rst_arready", {31'd0, o_arready}, 32'd1);

        read_expect("id",      32'h00, 32'h4D59_5245, 2'b00);
        read_expect("ctrl0",   32'h04, 32'h0, 2'b00);
        read_expect("scratch0",32'h08, 32'h0, 2'b00);
        read_expect("counter0",32'h0C, 32'h0, 2'b00);

        write_okay(32'h08, 32'hDEAD_BEEF, 4'b1111);
        write_okay(32'h08, 32'h0000_0011, 4'b0001);
        read_expect("scratch_strb", 32'h08, 32'hDEAD_BE11, 2'b00);
        read_expect("scratch_lowbits_ignored", 32'h0B, 32'hDEAD_BE11, 2'b00);

        for (int i = 0; i < 3; i++) begin
            bc = b_count;
            axi_write(32'h08, vals[i], 4'b1111, aw_s[i], w_s[i], 0, r, e0);
            repeat (3) @(negedge i_clk);
            check_eq("one_b_per_write", b_count, bc + 1);
            read_expect("order_readback", 32'h08, vals[i], 2'b00);
        end

        axi_write(32'h08, 32'hA5A5_A5A5, 4'b1111, 0, 0, 5, r, e0);
        check_eq("bready_hold_resp", {30'd0, r}, 32'd0);
        read_expect("bready_hold_data", 32'h08, 32'hA5A5_A5A5, 2'b00);

        write_okay(32'h00, 32'h1234_5678, 4'b1111);
        read_expect("id_ro", 32'h00, 32'h4D59_5245, 2'b00);

        axi_write(32'h10, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, r, e0);
        check_eq("unmapped_bresp", {30'd0, r}, 32'd2);
        read_expect("unmapped_read", 32'h10, 32'h0, 2'b10);
        read_expect("scratch_untouched", 32'h08, 32'hA5A5_A5A5, 2'b00);
        read_expect("ctrl_untouched", 32'h04, 32'h0, 2'b00);

        axi_write(32'h04, 32'h0000_0001, 4'b0001, 0, 0, 0, r, e0);
        check_eq("ctrl_en_out", {31'd0, o_ctrl_en}, 32'd1);
        repeat (10) @(negedge i_clk);
        axi_read(32'h0C, d, r, ka);
        check_eq("counter_running", d, ka - e0 - 1);

        axi_write(32'h04, 32'h0000_0000, 4'b1110, 0, 0, 0, r, e0);
        check_eq("ctrl_strb0_ignored", {31'd0, o_ctrl_en}, 32'd1);

        axi_write(32'h04, 32'h0000_0003, 4'b0001, 0, 0, 0, r, ec);
        axi_read(32'h0C, d, r, ka);
        check_eq("counter_after_clr", d, ka - ec - 1);
        read_expect("ctrl_clr_raz", 32'h04, 32'h1, 2'b00);

        @(negedge i_clk);
        i_araddr = 32'h00;
        i_arvalid = 1'b1;
        @(posedge i_clk);
        #1 i_arvalid = 1'b0;
        @(negedge i_clk);
        check_eq("rvalid_pending", {31'd0, o_rvalid}, 32'd1);
        i_sync_rst = 1'b1;
        #1;
        check_eq("rst_forces_awready", {31'd0, o_awready}, 32'd0);
        @(posedge i_clk);
        #1;
        check_eq("rst_drops_rvalid", {31'd0, o_rvalid}, 32'd0);
        check_eq("rst_clears_ctrl_en", {31'd0, o_ctrl_en}, 32'd0);
        @(negedge i_clk);
        i_sync_rst = 1'b0;
        #1;
        check_eq("rerst_arready", {31'd0, o_arready}, 32'd1);
        read_expect("ctrl_after_rst", 32'h04, 32'h0, 2'b00);
        read_expect("counter_after_rst", 32'h0C, 32'h0, 2'b00);
        read_expect("scratch_after_rst", 32'h08, 32'h0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d checks, expected completion", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/axi4_lite_reg_slave.md
# axi4_lite_reg_slave

AXI4-Lite slave register bank that sits directly downstream of the testbench's AXI4-Lite master agent; it is the DUT targeted by the UVM register model. It decodes 32-bit AXI4-Lite reads and writes into four 32-bit registers: an ID constant, a control register, a scratch register and a free-running event counter. It also exports the control enable to the rest of the design.

## Interface
- `ADDR_BIT_WIDTH`, 32, AXI4-Lite address width.
- `DATA_BIT_WIDTH`, 32, AXI4-Lite data width; only 32 is supported.
- `ID_VALUE`, 32'h4D59_5245, value returned by the ID register.
- `i_clk`  in  1  single clock.
- `i_sync_rst`  in  1  reset; synchronous, active-high.
- `i_awaddr`  in  ADDR_BIT_WIDTH  write address. `i_awvalid` in 1. `o_awready` out 1.
- `i_wdata`  in  DATA_BIT_WIDTH  write data. `i_wstrb` in DATA_BIT_WIDTH/8. `i_wvalid` in 1. `o_wready` out 1.
- `o_bresp`  out  2  write response. `o_bvalid` out 1. `i_bready` in 1.
- `i_araddr`  in  ADDR_BIT_WIDTH  read address. `i_arvalid` in 1. `o_arready` out 1.
- `o_rdata`  out  DATA_BIT_WIDTH  read data. `o_rresp` out 2. `o_rvalid` out 1. `i_rready` in 1.
- `o_ctrl_en`  out  1  copy of CTRL[0].

## Operation
- Register map (byte offsets):
  - 0x00 ID: RO, reads `ID_VALUE`.
  - 0x04 CTRL: RW.
    - Bit 0 = EN.
    - Bit 1 = CLR, write-1 pulse; always reads 0.
    - Bits 31:2 are RAZ/WI.
  - 0x08 SCRATCH: RW with full `wstrb` byte enables.
  - 0x0C COUNTER: RO.
- Address decode:
  - Only `addr[3:2]` selects the register.
  - Any `addr[ADDR_BIT_WIDTH-1:4] != 0` is unmapped.
  - `addr[1:0]` is ignored.
- Responses:
  - Mapped access returns OKAY (2'b00).
  - Unmapped access returns SLVERR (2'b10); the write is discarded and read data is 0.
  - Writes to RO registers are ignored and respond OKAY.
- CTRL byte enables: a CTRL write updates EN/CLR only if `wstrb[0]=1`.
- Write channel FSM:
  - States: W_IDLE, W_COMMIT, W_RESP.
  - W_IDLE: AW and W are captured independently. Each ready is high while its beat is not yet held.
  - When both beats are held, go to W_COMMIT. This includes both arriving in the same cycle.
  - W_COMMIT lasts one cycle: the register update and the response are registered, `o_bvalid`=1, go to W_RESP.
  - W_RESP: hold `o_bvalid`/`o_bresp` stable until `i_bready`, then return to W_IDLE.
  - `o_awready`/`o_wready` are 0 in W_COMMIT and W_RESP.
- Read channel:
  - `o_arready` = ~`o_rvalid`.
  - On handshake, `o_rdata`/`o_rresp` are registered, `o_rvalid`=1.
  - Data, response and valid are held until `i_rready`.
- Counter:
  - Increments by 1 each cycle while EN=1.
  - Wraps 0xFFFF_FFFF -> 0.
  - A CLR commit forces 0 at the commit edge; clear beats increment.
- Simultaneous read and write commit on the same register at the same edge: the read returns the pre-write value.
- The read and write channels are fully independent.

## Timing
- Reset values (outputs and state):
  - All outputs are 0, including the readies; the readies are forced 0 while `i_sync_rst`=1.
  - Internal state: CTRL=0, SCRATCH=0, COUNTER=0, FSM=W_IDLE.
- Reset has priority: handshakes in a reset cycle are ignored.
- Reset mid-transaction drops any held beat and any pending B/R response.
- All readies are 1 in the first cycle after reset deassertion.
- Write latency:
  - Last of the AW/W handshakes at edge N.
  - Register updated and `o_bvalid`=1 at edge N+1.
  - Minimum 3 cycles per write with `i_bready` tied high.
- Read latency:
  - AR handshake at edge N gives `o_rvalid`=1 with data after edge N.
  - A back-to-back read is possible every 2 cycles.
- COUNTER read value is the counter value at the AR handshake edge, before that edge's increment.
- `o_ctrl_en` changes at the commit edge.

## Structure
- Shared package `axi4_lite_reg_slave_pkg`:
  - Register offset constants.
  - `RESP_OKAY`/`RESP_SLVERR`.
  - Default ID value.
  - Write FSM state enum typedef.
  - CTRL bit index constants.
- Widths come from the verification params package values: 32/32, clock period 8 ns.
- Sub-module: `free_run_cnt` (width param; enable, sync clear, wrap). Everything else stays in one module.

## Test plan
- After reset, read 0x00 -> RDATA=0x4D595245, RRESP=OKAY. Read 0x04/0x08/0x0C -> 0.
- Write SCRATCH=0xDEADBEEF with wstrb=4'b1111, then write 0x00000011 with wstrb=4'b0001 -> read returns 0xDEADBE11.
- Order cases -> each gives exactly one B and the correct register update:
  - W before AW by 3 cycles.
  - AW before W.
  - Both in the same cycle.
- Hold `i_bready`=0 for 5 cycles -> `o_bvalid` stays high, BRESP stable, `o_awready`=0 throughout.
- Write CTRL=1, wait 10 cycles, read COUNTER -> value consistent with the cycle count.
  - Then write CTRL=3 -> COUNTER=0 at the commit edge, then counts up again. CTRL reads back 1.
- Write and read 0x10 -> BRESP=RRESP=SLVERR, RDATA=0, no register changed.
- Reset asserted while `o_rvalid`=1 -> `o_rvalid`=0 on the next edge.
